// File: rtl/prbs_gen_if.sv
// ============================================================================
//  Module   : prbs_gen_if
//  Brief    : Control/data bundle between a PRBS source and its consumer.
//             Optional err_inj line present when PRBS_ERR_INJ_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prbs_gen_if #(
    parameter int NCH = 2
) ();
    logic           enable;
    logic           valid;
    logic           load;
    logic [2:0]     mode;
`ifdef PRBS_ERR_INJ_EN
    logic           err_inj;
`endif
    logic [NCH-1:0] bit_out;
    logic           wrap;

    modport master (
        output enable, valid, load, mode,
`ifdef PRBS_ERR_INJ_EN
        output err_inj,
`endif
        input  bit_out, wrap
    );

    modport slave (
        input  enable, valid, load, mode,
`ifdef PRBS_ERR_INJ_EN
        input  err_inj,
`endif
        output bit_out, wrap
    );
endinterface

`default_nettype wire

// File: rtl/prbs_gen.sv
// ============================================================================
//  Module   : prbs_gen
//  Brief    : Multi-channel Fibonacci PRBS source, PRBS7/9/15/23/31 selectable
//             at load time. Optional macro PRBS_ERR_INJ_EN adds bit-error inject.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_gen #(
    parameter int                       NB_LFSR  = 31,
    parameter int                       NCH      = 2,
    parameter logic [NCH*NB_LFSR-1:0]   SEEDS    = {31'h1FE, 31'h1AA},
    parameter logic [2:0]               MODE_RST = 3'd1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prbs_gen_if.slave   bus
);

    localparam logic [NB_LFSR-1:0] c_one = {{(NB_LFSR-1){1'b0}}, 1'b1};

    function automatic int f_deg(input logic [2:0] m);
        case (m)
            3'd0:    return 7;
            3'd2:    return 15;
            3'd3:    return 23;
            3'd4:    return 31;
            default: return 9;
        endcase
    endfunction

    // Distance from the output bit to the second feedback tap (N-M).
    function automatic int f_tap(input logic [2:0] m);
        case (m)
            3'd0:    return 1;
            3'd2:    return 1;
            3'd3:    return 5;
            3'd4:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [NB_LFSR-1:0] f_mask(input logic [2:0] m);
        return {NB_LFSR{1'b1}} >> (NB_LFSR - f_deg(m));
    endfunction

    // An all-zero seed after masking would lock the LFSR, so substitute 1.
    function automatic logic [NB_LFSR-1:0] f_eff_seed(input int k, input logic [2:0] m);
        logic [NB_LFSR-1:0] s;
        s = SEEDS[k*NB_LFSR +: NB_LFSR] & f_mask(m);
        if (s == '0) begin
            s = c_one;
        end
        return s;
    endfunction

    logic [2:0]                     r_mode;
    logic [NCH-1:0][NB_LFSR-1:0]    r_state;
    logic                           r_wrap;
`ifdef PRBS_ERR_INJ_EN
    logic                           r_inj;
`endif

    logic [NB_LFSR-1:0]             w_mask;
    logic [4:0]                     w_tap;
    logic [4:0]                     w_msb;
    logic [NCH-1:0]                 w_fb;
    logic [NCH-1:0]                 w_zero;
    logic [NCH-1:0][NB_LFSR-1:0]    w_next;
    logic [NCH-1:0]                 w_bits;
    logic                           w_adv;

    assign w_adv = bus.enable & bus.valid;

    always_comb begin
        w_mask = f_mask(r_mode);
        w_tap  = 5'(f_tap(r_mode));
        w_msb  = 5'(f_deg(r_mode) - 1);
        w_fb   = '0;
        w_zero = '0;
        w_next = '0;
        for (int k = 0; k < NCH; k++) begin
            w_zero[k] = ((r_state[k] & w_mask) == '0);
            w_fb[k]   = r_state[k][0] ^ r_state[k][w_tap];
            w_next[k] = w_zero[k] ? c_one
                      : (((r_state[k] >> 1) | (NB_LFSR'(w_fb[k]) << w_msb)) & w_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode <= MODE_RST;
            for (int k = 0; k < NCH; k++) begin
                r_state[k] <= f_eff_seed(k, MODE_RST);
            end
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_mode <= bus.mode;
            for (int k = 0; k < NCH; k++) begin
                r_state[k] <= f_eff_seed(k, bus.mode);
            end
            r_wrap <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_next;
            r_wrap  <= (w_next[0] == f_eff_seed(0, r_mode));
        end else begin
            r_wrap <= 1'b0;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    // Inversion lives only on the output path; the LFSR keeps running clean.
    always_ff @(posedge clk) begin
        if (!rst || bus.load) begin
            r_inj <= 1'b0;
        end else begin
            r_inj <= w_adv & bus.err_inj;
        end
    end
`endif

    always_comb begin
        w_bits = '0;
        for (int k = 0; k < NCH; k++) begin
            w_bits[k] = r_state[k][0];
        end
`ifdef PRBS_ERR_INJ_EN
        w_bits[0] = r_state[0][0] ^ r_inj;
`endif
    end

    assign bus.bit_out = w_bits;
    assign bus.wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_prbs_gen.sv
// ============================================================================
//  Module   : tb_prbs_gen
//  Brief    : Self-checking bench for prbs_gen against an output-recurrence
//             model (o[t+N] = o[t] ^ o[t+N-M]) and a period counter for wrap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_gen;

    localparam int                  NB  = 31;
    localparam int                  NCH = 2;
    localparam logic [NCH*NB-1:0]   c_SEEDS = {31'h180, 31'h1AA};
    localparam logic [2:0]          c_MODE_RST = 3'd1;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 0;

    prbs_gen_if #(.NCH(NCH)) bus_if ();

    prbs_gen #(
        .NB_LFSR  (NB),
        .NCH      (NCH),
        .SEEDS    (c_SEEDS),
        .MODE_RST (c_MODE_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial table: degree and tap distance for each mode.
    function automatic int deg_of(input logic [2:0] m);
        case (m)
            3'd0:    return 7;
            3'd2:    return 15;
            3'd3:    return 23;
            3'd4:    return 31;
            default: return 9;
        endcase
    endfunction

    function automatic int tapd_of(input logic [2:0] m);
        case (m)
            3'd0:    return 1;
            3'd2:    return 1;
            3'd3:    return 5;
            3'd4:    return 3;
            default: return 4;
        endcase
    endfunction

    task automatic hchk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per channel, a queue holding the next N output bits.
    bit         mq [NCH][$];
    logic [2:0] m_mode;
    longint     m_cnt;
    bit         m_wrap;
    bit         m_inj;

    task automatic reload(input logic [2:0] m);
        longint e;
        int     n;
        n = deg_of(m);
        for (int ch = 0; ch < NCH; ch++) begin
            e = longint'(c_SEEDS[ch*NB +: NB]) & ((longint'(1) << n) - 1);
            if (e == 0) e = 1;
            mq[ch].delete();
            for (int i = 0; i < n; i++) mq[ch].push_back(bit'((e >> i) & 1));
        end
        m_mode = m;
        m_cnt  = 0;
        m_wrap = 0;
        m_inj  = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            reload(c_MODE_RST);
        end else if (bus_if.load) begin
            reload(bus_if.mode);
        end else if (bus_if.enable && bus_if.valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
                bit nb;
                nb = mq[ch][0] ^ mq[ch][tapd_of(m_mode)];
                void'(mq[ch].pop_front());
                mq[ch].push_back(nb);
            end
            m_cnt++;
            m_wrap = ((m_cnt % ((longint'(1) << deg_of(m_mode)) - 1)) == 0);
`ifdef PRBS_ERR_INJ_EN
            m_inj = bus_if.err_inj;
`else
            m_inj = 0;
`endif
        end else begin
            m_wrap = 0;
            m_inj  = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int ch = 0; ch < NCH; ch++) begin
                bit e;
                e = mq[ch][0] ^ ((ch == 0) ? m_inj : 1'b0);
                hchk($sformatf("bit_out[%0d]", ch), longint'(bus_if.bit_out[ch]), longint'(e));
            end
            hchk("wrap", longint'(bus_if.wrap), longint'(m_wrap));
        end
    end

    // One clock: inputs set after the falling edge, outputs observed 1ns after rise.
    task automatic step(input bit r, input bit en, input bit vl, input bit ld,
                        input logic [2:0] md, input bit inj);
        @(negedge clk);
        rst            = r;
        bus_if.enable  = en;
        bus_if.valid   = vl;
        bus_if.load    = ld;
        bus_if.mode    = md;
`ifdef PRBS_ERR_INJ_EN
        bus_if.err_inj = inj;
`else
        if (inj) begin end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit     exp1 [10];
        int     w1, w2;
        rst            = 1'b0;
        bus_if.enable  = 1'b0;
        bus_if.valid   = 1'b0;
        bus_if.load    = 1'b0;
        bus_if.mode    = 3'd0;
`ifdef PRBS_ERR_INJ_EN
        bus_if.err_inj = 1'b0;
`endif
        exp1 = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0};

        // Reset and PRBS9 opening sequence from seed 0x1AA.
        step(0, 0, 0, 0, 3'd0, 0);
        chk_on = 1;
        step(0, 0, 0, 0, 3'd0, 0);
        hchk("rst_bit0", longint'(bus_if.bit_out[0]), 0);
        hchk("rst_bit1", longint'(bus_if.bit_out[1]), 0);
        hchk("rst_wrap", longint'(bus_if.wrap), 0);
        for (int i = 1; i < 10; i++) begin
            step(1, 1, 1, 0, 3'd0, 0);
            hchk($sformatf("prbs9_bit%0d", i), longint'(bus_if.bit_out[0]), longint'(exp1[i]));
        end

        // PRBS7: ch1 seed 0x180 masks to zero and must become 1.
        step(1, 0, 0, 1, 3'd0, 0);
        hchk("p7_seed_bit0", longint'(bus_if.bit_out[0]), 0);
        hchk("p7_zero_seed_bit1", longint'(bus_if.bit_out[1]), 1);
        w1 = 0; w2 = 0;
        for (int n = 1; n <= 300; n++) begin
            step(1, 1, 1, 0, 3'd0, 0);
            if (bus_if.wrap) begin
                if (w1 == 0) w1 = n; else if (w2 == 0) w2 = n;
            end
        end
        hchk("p7_wrap_first", w1, 127);
        hchk("p7_wrap_second", w2, 254);

        // Load with valid high: no advance on the load cycle.
        step(1, 1, 1, 1, 3'd1, 0);
        hchk("load_valid_bit0", longint'(bus_if.bit_out[0]), 0);
        w1 = 0; w2 = 0;
        for (int n = 1; n <= 1100; n++) begin
            step(1, 1, 1, 0, 3'd1, 0);
            if (n == 1) hchk("load_valid_next", longint'(bus_if.bit_out[0]), 1);
            if (bus_if.wrap) begin
                if (w1 == 0) w1 = n; else if (w2 == 0) w2 = n;
            end
        end
        hchk("p9_wrap_first", w1, 511);
        hchk("p9_wrap_second", w2, 1022);

        // Hold with enable=1, valid=0, then mid-sequence reset.
        for (int i = 0; i < 37; i++) step(1, 1, 1, 0, 3'd5, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 3'd2, 0);
        for (int i = 0; i < 5; i++)  step(1, 1, 1, 0, 3'd3, 0);
        step(0, 1, 1, 1, 3'd4, 0);
        hchk("midrst_bit0", longint'(bus_if.bit_out[0]), 0);
        hchk("midrst_wrap", longint'(bus_if.wrap), 0);

        // Randomised walk over every mode; mode toggles freely without load.
        for (int m = 0; m < 8; m++) begin
            step(1, 0, 0, 1, 3'(m), 0);
            for (int i = 0; i < ((m < 5) ? 10000 : 1000); i++) begin
                bit ld;
                ld = ($urandom_range(0, 2999) == 0);
                step(1,
                     ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 9) != 0),
                     ld,
                     ld ? 3'(m) : 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 49) == 0));
            end
        end

        step(1, 0, 0, 0, 3'd0, 0);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
